hack_cpu_ctrl: RTL and testbench

HACK_CPU_CTRL -- requirements
Module: hack_cpu_ctrl

---
 rtl/hack_pkg.sv | 31 +++
 rtl/hack_decode.sv | 23 ++
 rtl/hack_cpu_ctrl.sv | 123 ++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU controller: FSM encodings, instruction
// field positions and the jump-condition helper.
package hack_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_MREAD  = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_MWRITE = 3'd4;

  localparam int A_BIT    = 15;
  localparam int ABIT_SEL = 12;
  localparam int COMP_HI  = 11;
  localparam int COMP_LO  = 6;
  localparam int DEST_HI  = 5;
  localparam int DEST_LO  = 3;
  localparam int JUMP_HI  = 2;
  localparam int JUMP_LO  = 0;

  localparam int DEST_M = 0;
  localparam int DEST_D = 1;
  localparam int DEST_A = 2;

  // jump bits are {lt,eq,gt}; gt means strictly positive (not negative, not zero)
  function automatic logic jump_taken(input logic [2:0] j, input logic n, input logic z);
    return (j[2] & n) | (j[1] & z) | (j[0] & ~n & ~z);
  endfunction

endpackage

// File: rtl/hack_decode.sv
// Combinational split of a Hack instruction word plus jump-condition evaluation.
module hack_decode
  import hack_pkg::*;
(
  input  logic [15:0] instr,
  input  logic        n,
  input  logic        z,
  output logic        is_c,
  output logic        a_sel,
  output logic [5:0]  comp,
  output logic [2:0]  dest,
  output logic [2:0]  jump,
  output logic        taken
);

  assign is_c  = instr[A_BIT];
  assign a_sel = instr[ABIT_SEL];
  assign comp  = instr[COMP_HI:COMP_LO];
  assign dest  = instr[DEST_HI:DEST_LO];
  assign jump  = instr[JUMP_HI:JUMP_LO];
  assign taken = jump_taken(jump, n, z);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU controller: owns A/D/M/PC, sequences fetch, optional
// M read, execute on an external ALU, optional M write, and commit.
module hack_cpu_ctrl
  import hack_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [14:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [14:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_fn,
  input  logic [15:0] alu_out,
  input  logic        alu_zero,
  output logic [14:0] pc
);

  state_t      state;
  logic        run;
  logic [14:0] pc_q;
  logic [15:0] a_q, d_q, m_q, instr, res;
  logic        z_q, n_q;

  logic        is_c, a_sel, taken;
  logic [5:0]  comp;
  logic [2:0]  dest, jump;
  logic        n_sel, z_sel;
  logic        do_commit;
  logic [15:0] cval;
  logic [14:0] pc_inc;

  // EXEC commits directly when there is no M write, so flags come straight off the ALU
  assign n_sel = (state == S_EXEC) ? alu_out[15] : n_q;
  assign z_sel = (state == S_EXEC) ? alu_zero    : z_q;

  hack_decode u_dec (
    .instr (instr),
    .n     (n_sel),
    .z     (z_sel),
    .is_c  (is_c),
    .a_sel (a_sel),
    .comp  (comp),
    .dest  (dest),
    .jump  (jump),
    .taken (taken)
  );

  // run holds requests low for the first cycle out of reset
  assign imem_req   = (state == S_FETCH) && run;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state == S_MREAD) || (state == S_MWRITE);
  assign dmem_we    = (state == S_MWRITE);
  assign dmem_addr  = a_q[14:0];
  assign dmem_wdata = res;
  assign alu_x      = d_q;
  assign alu_y      = a_sel ? m_q : a_q;
  assign alu_fn     = comp;
  assign pc         = pc_q;
  assign pc_inc     = pc_q + 15'd1;

  assign do_commit = ((state == S_EXEC) && !dest[DEST_M]) ||
                     ((state == S_MWRITE) && dmem_ack);
  assign cval      = (state == S_EXEC) ? alu_out : res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      run   <= 1'b0;
      pc_q  <= '0;
      a_q   <= '0;
      d_q   <= '0;
      m_q   <= '0;
      instr <= '0;
      res   <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        S_FETCH: if (run && imem_ack) begin
          instr <= imem_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (!is_c) begin
            a_q   <= {1'b0, instr[14:0]};
            pc_q  <= pc_inc;
            state <= S_FETCH;
          end else begin
            state <= a_sel ? S_MREAD : S_EXEC;
          end
        end
        S_MREAD: if (dmem_ack) begin
          m_q   <= dmem_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res   <= alu_out;
          z_q   <= alu_zero;
          n_q   <= alu_out[15];
          state <= dest[DEST_M] ? S_MWRITE : S_FETCH;
        end
        S_MWRITE: if (dmem_ack) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
      // jump target and write address use A before this commit
      if (do_commit) begin
        if (dest[DEST_D]) d_q <= cval;
        if (dest[DEST_A]) a_q <= cval;
        pc_q <= taken ? a_q[14:0] : pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl with behavioural instruction/data memories
// and a reference Hack ALU.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, dmem_req, dmem_we;
  logic [14:0] imem_addr, dmem_addr, pc;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [15:0] imem_data = '0, dmem_rdata = '0, dmem_wdata;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_fn;
  logic        alu_zero;

  int checks = 0;
  int fails  = 0;

  logic [15:0] rom [0:63];
  logic [15:0] ram [0:63];
  int   imem_lat = 0, dmem_lat = 0, icnt = 0, dcnt = 0, wr_count = 0;
  logic dmem_spur = 1'b0;

  hack_cpu_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_fn(alu_fn), .alu_out(alu_out), .alu_zero(alu_zero),
    .pc(pc)
  );

  always #5 clk = ~clk;

  // reference Hack ALU: {zx,nx,zy,ny,f,no}
  always_comb begin
    logic [15:0] x, y, r;
    x = alu_fn[5] ? 16'h0 : alu_x;
    x = alu_fn[4] ? ~x : x;
    y = alu_fn[3] ? 16'h0 : alu_y;
    y = alu_fn[2] ? ~y : y;
    r = alu_fn[1] ? (x + y) : (x & y);
    r = alu_fn[0] ? ~r : r;
    alu_out  = r;
    alu_zero = (r == 16'h0);
  end

  // memory responders: ack after a configurable number of wait cycles
  always @(negedge clk) begin
    if (imem_req) begin
      imem_ack  = (icnt >= imem_lat);
      imem_data = rom[imem_addr[5:0]];
      icnt      = imem_ack ? 0 : icnt + 1;
    end else begin
      imem_ack = 1'b0;
      icnt     = 0;
    end
    if (dmem_req) begin
      dmem_ack   = (dcnt >= dmem_lat);
      dmem_rdata = ram[dmem_addr[5:0]];
      dcnt       = dmem_ack ? 0 : dcnt + 1;
    end else begin
      dmem_ack = dmem_spur;
      dcnt     = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst && dmem_req && dmem_we && dmem_ack) begin
      ram[dmem_addr[5:0]] = dmem_wdata;
      wr_count = wr_count + 1;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      rom[i] = 16'h8000;
      ram[i] = 16'h0000;
    end
    imem_lat  = 0;
    dmem_lat  = 0;
    dmem_spur = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    wr_count = 0;
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++; if (pc !== 15'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", pc); end
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin fails++; $display("FAIL reset_dmem: got req=%b we=%b want 0 0", dmem_req, dmem_we); end
    checks++; if (alu_x !== 16'h0 || dmem_addr !== 15'h0 || alu_fn !== 6'h0) begin fails++; $display("FAIL reset_regs: got D=%h A=%h fn=%h want 0", alu_x, dmem_addr, alu_fn); end
    rst = 1'b0;
    step(1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 15'h0) begin fails++; $display("FAIL reset_first_fetch: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
  endtask

  task automatic test_load_const();
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hEC10;
    dmem_spur = 1'b1;
    do_reset();
    step(6);
    checks++; if (pc !== 15'd2) begin fails++; $display("FAIL load_pc: got %h want 2", pc); end
    checks++; if (dmem_addr !== 15'd5) begin fails++; $display("FAIL load_A: got %h want 5", dmem_addr); end
    checks++; if (alu_x !== 16'd5) begin fails++; $display("FAIL load_D: got %h want 5", alu_x); end
    checks++; if (wr_count !== 0) begin fails++; $display("FAIL load_spurious_ack: got %0d writes want 0", wr_count); end
    dmem_spur = 1'b0;
  endtask

  task automatic test_mem_read();
    clear_mem();
    rom[0] = 16'h0003; rom[1] = 16'hEC10; rom[2] = 16'h0005; rom[3] = 16'hF090;
    ram[5] = 16'd7;
    do_reset();
    step(10);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 15'd5) begin fails++; $display("FAIL mread_req: got req=%b we=%b addr=%h want 1 0 5", dmem_req, dmem_we, dmem_addr); end
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL mread_excl: got imem_req=%b want 0", imem_req); end
    step(2);
    checks++; if (alu_x !== 16'd10) begin fails++; $display("FAIL mread_D: got %h want 000a", alu_x); end
    checks++; if (pc !== 15'd4) begin fails++; $display("FAIL mread_pc: got %h want 4", pc); end
  endtask

  task automatic test_mem_write();
    clear_mem();
    rom[0] = 16'h1234; rom[1] = 16'hEC10; rom[2] = 16'h0010; rom[3] = 16'hE308;
    do_reset();
    step(11);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 15'h10 || dmem_wdata !== 16'h1234) begin fails++; $display("FAIL mwrite_req: got req=%b we=%b addr=%h data=%h want 1 1 0010 1234", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    step(1);
    checks++; if (wr_count !== 1 || ram[16] !== 16'h1234) begin fails++; $display("FAIL mwrite_mem: got count=%0d M=%h want 1 1234", wr_count, ram[16]); end
    checks++; if (dmem_addr !== 15'h10 || alu_x !== 16'h1234) begin fails++; $display("FAIL mwrite_AD: got A=%h D=%h want 0010 1234", dmem_addr, alu_x); end
    checks++; if (pc !== 15'd4) begin fails++; $display("FAIL mwrite_pc: got %h want 4", pc); end
  endtask

  task automatic test_jump();
    clear_mem();
    rom[0] = 16'h0000; rom[1] = 16'hEC10; rom[2] = 16'h0020; rom[3] = 16'hE302;
    do_reset();
    step(11);
    checks++; if (pc !== 15'h20) begin fails++; $display("FAIL jeq_taken: got pc=%h want 0020", pc); end
    rom[0] = 16'h0001;
    do_reset();
    step(11);
    checks++; if (pc !== 15'd4) begin fails++; $display("FAIL jeq_not_taken: got pc=%h want 0004", pc); end
    clear_mem();
    rom[0] = 16'h7FFF; rom[1] = 16'hEC10; rom[2] = 16'hE7D0; rom[3] = 16'h0020; rom[4] = 16'hE304;
    do_reset();
    step(14);
    checks++; if (pc !== 15'h20 || alu_x !== 16'h8000) begin fails++; $display("FAIL jlt_taken: got pc=%h D=%h want 0020 8000", pc, alu_x); end
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[63] = 16'h0005;
    do_reset();
    step(6);
    checks++; if (pc !== 15'h7FFF || dmem_addr !== 15'h7FFF) begin fails++; $display("FAIL jmp_uncond: got pc=%h A=%h want 7fff 7fff", pc, dmem_addr); end
    step(2);
    checks++; if (pc !== 15'h0 || dmem_addr !== 15'd5) begin fails++; $display("FAIL pc_wrap: got pc=%h A=%h want 0000 0005", pc, dmem_addr); end
  endtask

  task automatic test_wait_states();
    clear_mem();
    rom[0] = 16'hEC10;
    imem_lat = 3;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      step(1);
      checks++; if (imem_req !== 1'b1 || alu_fn !== 6'h00) begin fails++; $display("FAIL fetch_wait_c%0d: got req=%b fn=%h want 1 00", c, imem_req, alu_fn); end
    end
    step(1);
    checks++; if (imem_req !== 1'b0 || alu_fn !== 6'h30) begin fails++; $display("FAIL fetch_latch: got req=%b fn=%h want 0 30", imem_req, alu_fn); end
    step(2);
    checks++; if (pc !== 15'd1) begin fails++; $display("FAIL fetch_wait_pc: got %h want 1", pc); end
  endtask

  task automatic test_reset_mid_write();
    clear_mem();
    rom[0] = 16'h0010; rom[1] = 16'hE308;
    dmem_lat = 5;
    do_reset();
    step(7);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin fails++; $display("FAIL rst_mw_pending: got req=%b we=%b want 1 1", dmem_req, dmem_we); end
    rst = 1'b1;
    step(1);
    checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL rst_mw_abort: got dreq=%b ireq=%b want 0 0", dmem_req, imem_req); end
    checks++; if (pc !== 15'h0 || dmem_addr !== 15'h0 || wr_count !== 0) begin fails++; $display("FAIL rst_mw_state: got pc=%h A=%h writes=%0d want 0 0 0", pc, dmem_addr, wr_count); end
    rst = 1'b0;
    dmem_lat = 0;
  endtask

  task automatic test_am_inc();
    clear_mem();
    rom[0] = 16'h0007; rom[1] = 16'hFDE8;
    ram[7] = 16'd9;
    do_reset();
    step(7);
    checks++; if (dmem_we !== 1'b1 || dmem_addr !== 15'd7 || dmem_wdata !== 16'd10) begin fails++; $display("FAIL am_write: got we=%b addr=%h data=%h want 1 0007 000a", dmem_we, dmem_addr, dmem_wdata); end
    step(1);
    checks++; if (ram[7] !== 16'd10 || wr_count !== 1) begin fails++; $display("FAIL am_mem: got M=%h writes=%0d want 000a 1", ram[7], wr_count); end
    checks++; if (dmem_addr !== 15'd10 || pc !== 15'd2) begin fails++; $display("FAIL am_A_pc: got A=%h pc=%h want 000a 0002", dmem_addr, pc); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_load_const();
    test_mem_read();
    test_mem_write();
    test_jump();
    test_pc_wrap();
    test_wait_states();
    test_reset_mid_write();
    test_am_inc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
